// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the buffered UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam logic StartBit = 1'b0;
    localparam logic StopBit  = 1'b1;
    localparam logic IdleBit  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous word FIFO feeding the UART transmitter; full is registered, empty is decoded.
module uart_tx_fifo_buf #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             push, pop;

    // A write is refused whenever full was set before this edge, even if a pop frees a slot now.
    assign push      = wr_en_i & ~full_q;
    assign pop       = rd_en_i & ~empty_o;
    assign empty_o   = (count_q == '0);
    assign full_o    = full_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == CntW'(Depth));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame FSM with per-bit prescaler, optional parity, 1/2 stops.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      full
);

    localparam int unsigned BitW = $clog2(DATA_WIDTH);

    logic                      fifo_empty;
    logic                      fifo_pop;
    logic [DATA_WIDTH-1:0]     fifo_head;

    tx_state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
    logic [BitW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRESCALE_WIDTH-1:0] reload_q, reload_d;
    logic                      par_en_q, par_en_d;
    logic                      par_bit_q, par_bit_d;
    logic                      stop2_q, stop2_d;
    logic                      second_stop_q, second_stop_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic                      bit_end;
    logic                      start_frame;
    logic [PRESCALE_WIDTH-1:0] eff_reload;

    uart_tx_fifo_buf #(
        .Width (DATA_WIDTH),
        .Depth (DEPTH)
    ) u_buf (
        .clk_i     (CLK),
        .rst_i     (RST),
        .wr_en_i   (Data_valid),
        .wr_data_i (P_DATA),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_head),
        .full_o    (full),
        .empty_o   (fifo_empty)
    );

    // Counter runs Prescale-1 .. 0 per bit; a Prescale of 0 behaves as 1.
    assign eff_reload = (Prescale == '0) ? '0 : Prescale - 1'b1;
    assign bit_end    = (presc_cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        presc_cnt_d   = presc_cnt_q;
        reload_d      = reload_q;
        par_en_d      = par_en_q;
        par_bit_d     = par_bit_q;
        stop2_d       = stop2_q;
        second_stop_d = second_stop_q;
        tx_d          = tx_q;
        busy_d        = busy_q;
        fifo_pop      = 1'b0;
        start_frame   = 1'b0;

        if (state_q != StIdle && !bit_end) begin
            presc_cnt_d = presc_cnt_q - 1'b1;
        end

        case (state_q)
            StIdle: begin
                tx_d   = IdleBit;
                busy_d = 1'b0;
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d     = StData;
                    bit_cnt_d   = '0;
                    tx_d        = shreg_q[0];
                    presc_cnt_d = reload_q;
                end
            end
            StData: begin
                if (bit_end) begin
                    presc_cnt_d = reload_q;
                    if (bit_cnt_q == BitW'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d       = StStop;
                            tx_d          = StopBit;
                            second_stop_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shreg_q[1];
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d       = StStop;
                    tx_d          = StopBit;
                    second_stop_d = 1'b0;
                    presc_cnt_d   = reload_q;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (stop2_q && !second_stop_q) begin
                        second_stop_d = 1'b1;
                        presc_cnt_d   = reload_q;
                    end else if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = StIdle;
                        tx_d    = IdleBit;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = IdleBit;
                busy_d  = 1'b0;
            end
        endcase

        // Frame config is captured only here so mid-frame input changes affect the next frame.
        if (start_frame) begin
            fifo_pop    = 1'b1;
            shreg_d     = fifo_head;
            par_en_d    = PAR_EN;
            par_bit_d   = PAR_TYP ? ~^fifo_head : ^fifo_head;
            stop2_d     = STOP2;
            reload_d    = eff_reload;
            presc_cnt_d = eff_reload;
            state_d     = StStart;
            tx_d        = StartBit;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= StIdle;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            presc_cnt_q   <= '0;
            reload_q      <= '0;
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
            stop2_q       <= 1'b0;
            second_stop_q <= 1'b0;
            tx_q          <= IdleBit;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            presc_cnt_q   <= presc_cnt_d;
            reload_q      <= reload_d;
            par_en_q      <= par_en_d;
            par_bit_q     <= par_bit_d;
            stop2_q       <= stop2_d;
            second_stop_q <= second_stop_d;
            tx_q          <= tx_d;
            busy_q        <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: randomized and directed traffic against a queue-based line model.
module tb_uart_tx_fifo;

    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int PW  = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          Data_valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          STOP2;
    logic [PW-1:0] Prescale;
    logic          TX_OUT;
    logic          busy;
    logic          full;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cnt = 0;
    logic [63:0] tx_hist = '0;

    logic [DW-1:0] mq[$];  // model FIFO contents
    bit            lq[$];  // expected line value after each coming edge

    uart_tx_fifo #(
        .DATA_WIDTH     (DW),
        .DEPTH          (DEP),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .full       (full)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void build_frame(input logic [DW-1:0] d);
        bit b[$];
        int p;
        p = (Prescale == 0) ? 1 : int'(Prescale);
        b.push_back(1'b0);
        for (int i = 0; i < DW; i++) b.push_back(d[i]);
        if (PAR_EN) b.push_back(PAR_TYP ? ~^d : ^d);
        b.push_back(1'b1);
        if (STOP2) b.push_back(1'b1);
        foreach (b[i]) for (int k = 0; k < p; k++) lq.push_back(b[i]);
    endfunction

    // Advance model by one edge using the current inputs, then sample the DUT just after it.
    task automatic step();
        int pre;
        pre = mq.size();
        if (lq.size() > 0) void'(lq.pop_front());
        if (lq.size() == 0 && pre > 0) build_frame(mq.pop_front());
        if (Data_valid && pre < DEP) mq.push_back(P_DATA);
        @(posedge CLK);
        #1;
        check_eq("tx", TX_OUT, (lq.size() > 0) ? lq[0] : 1'b1);
        check_eq("busy", busy, lq.size() > 0);
        check_eq("full", full, mq.size() == DEP);
        if (busy) begin
            busy_cnt++;
            tx_hist = {tx_hist[62:0], TX_OUT};
        end
    endtask

    task automatic cfg(input int p, input bit pe, input bit pt, input bit s2);
        Prescale = PW'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        STOP2    = s2;
    endtask

    task automatic write(input logic [DW-1:0] d);
        P_DATA     = d;
        Data_valid = 1'b1;
        step();
        Data_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (lq.size() == 0 && mq.size() == 0) break;
            step();
        end
        check_eq("idle_after_drain", busy, 1'b0);
    endtask

    task automatic new_test();
        busy_cnt = 0;
        tx_hist  = '0;
    endtask

    initial begin
        RST        = 1'b1;
        Data_valid = 1'b0;
        P_DATA     = '0;
        cfg(1, 0, 0, 0);
        #2;
        check_eq("rst_tx", TX_OUT, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_full", full, 1'b0);
        #1 RST = 1'b0;

        // Single frame, one clock per bit.
        new_test();
        write(8'hA5);
        drain();
        check_eq("a5_busy_len", busy_cnt, 10);
        check_eq("a5_bits", tx_hist[9:0], 10'b0101001011);

        // Even parity, 4 clocks per bit.
        new_test();
        cfg(4, 1, 0, 0);
        write(8'h03);
        drain();
        check_eq("p4_busy_len", busy_cnt, 44);

        // Odd parity on zero data, two stop bits.
        new_test();
        cfg(2, 1, 1, 1);
        write(8'h00);
        drain();
        check_eq("odd_busy_len", busy_cnt, 24);
        check_eq("odd_bits", tx_hist[23:0], 24'h00003F);

        // Overfill: sixth word dropped, five frames back-to-back.
        new_test();
        cfg(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            write(DW'(8'h11 + i));
            if (i == 4) check_eq("full_after_5th", full, 1'b1);
        end
        drain();
        check_eq("burst_busy_len", busy_cnt, 50);

        // Asynchronous reset during data bit 3 with the FIFO full.
        new_test();
        cfg(1, 0, 0, 0);
        write(8'hFF);
        for (int i = 1; i < 5; i++) write(DW'(i));
        step();
        check_eq("pre_rst_full", full, 1'b1);
        RST = 1'b1;
        #1;
        check_eq("mid_rst_tx", TX_OUT, 1'b1);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_full", full, 1'b0);
        mq.delete();
        lq.delete();
        #2 RST = 1'b0;
        new_test();
        write(8'h5A);
        drain();
        check_eq("post_rst_busy_len", busy_cnt, 10);
        check_eq("post_rst_bits", tx_hist[9:0], 10'b0010110101);

        // Config changed mid-frame applies only to the following frame.
        new_test();
        cfg(3, 0, 0, 0);
        write(8'h3C);
        write(8'hC3);
        for (int i = 0; i < 5; i++) step();
        cfg(2, 1, 0, 1);
        drain();
        check_eq("cfg_change_busy_len", busy_cnt, 54);

        // Randomized traffic and configuration, including Prescale=0.
        cfg(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            Data_valid = ($urandom_range(0, 3) == 0);
            P_DATA     = DW'($urandom);
            if ($urandom_range(0, 15) == 0)
                cfg($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        Data_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, a per-bit baud prescaler, configurable data width, optional parity and one or two stop bits. It replaces the single-shot UART transmitter, which has a fixed 8-bit data width, one clock per bit and no buffering. It sits between the system-side producer (parallel words with a valid strobe) and the serial line. The FIFO lets frames go out back-to-back with no idle cycle between the stop bit and the next start bit.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, 5..9.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `PRESCALE_WIDTH`, 8: width of `Prescale`.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `P_DATA` input DATA_WIDTH: word to transmit.
- `Data_valid` input 1: write strobe for `P_DATA`, sampled each rising edge.
- `PAR_EN` input 1: 1 inserts a parity bit after the data bits.
- `PAR_TYP` input 1: 0 selects even parity, 1 selects odd parity.
- `STOP2` input 1: 1 sends two stop bits.
- `Prescale` input PRESCALE_WIDTH: clocks per serial bit. A value of 0 is treated as 1.
- `TX_OUT` output 1: serial line. Idles high. Registered.
- `busy` output 1: high while a frame is on the line. Registered.
- `full` output 1: FIFO holds DEPTH words. Registered.

## Operation
- Write: `Data_valid`=1 at an edge with `full`=0 stores `P_DATA`. A write while `full`=1 is dropped silently. This holds even if a pop happens at the same edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1, `busy`=0. If the FIFO is non-empty at an edge:
  - pop the head word;
  - latch `PAR_EN`, `PAR_TYP`, `STOP2` and `Prescale` into frame registers;
  - go to START.
- Config inputs are ignored mid-frame. Only the latched copies are used.
- START: `TX_OUT`=0 for one bit time, then go to DATA.
- DATA: send DATA_WIDTH bits, LSB first, one bit time each. Then go to PARITY if the latched PAR_EN=1, otherwise to STOP.
- PARITY: one bit time.
  - Even parity: `^data`.
  - Odd parity: `~^data`.
- STOP: `TX_OUT`=1 for one bit time, or two if the latched STOP2=1. At the end of the final stop-bit time:
  - FIFO non-empty: pop and go directly to START, with a fresh config latch.
  - FIFO empty: go to IDLE.
- Bit time: latched Prescale clocks, counted by a down-counter reloaded at each bit boundary. Prescale=1 gives one clock per bit.
- Frame length = (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) × Prescale clocks.

## Timing
- Reset values: `TX_OUT`=1, `busy`=0, `full`=0. FIFO pointers and count are 0, state is IDLE, and the bit and prescale counters are 0.
- Reset mid-frame: outputs return to their reset values immediately, without waiting for a clock. FIFO contents are discarded. The next write after reset is released transmits normally.
- Latency: with the FIFO empty and state IDLE, `Data_valid` sampled at edge k gives `TX_OUT`=0 and `busy`=1 after edge k+1.
- Back-to-back frames: `busy` stays 1 and there are zero idle clocks between the last stop bit and the next start bit.
- `full` updates at the same edge as the write or pop that changes the count.
- Simultaneous write and pop when not full: count is unchanged and both happen.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

## Structure
- Package `uart_tx_pkg`:
  - FSM state typedef/constants (IDLE, START, DATA, PARITY, STOP);
  - bit-value constants for start, stop and idle.
- One sub-module, `uart_tx_fifo_buf`: synchronous FIFO (DATA_WIDTH × DEPTH) with write/pop, `full` and `empty`.
- The FSM, prescaler, bit counter and parity generator live in the top module.

## Test plan
- Prescale=1, PAR_EN=0, STOP2=0, write 8'hA5 once:
  - `TX_OUT` bits, one clock each: 0,1,0,1,0,0,1,0,1,1;
  - `busy`=1 for exactly 10 clocks, then 0.
- Prescale=4, PAR_EN=1, PAR_TYP=0, write 8'h03:
  - frame: start, data 1,1,0,0,0,0,0,0, parity 0, stop;
  - each bit held 4 clocks; `busy` high 44 clocks.
- Prescale=2, PAR_EN=1, PAR_TYP=1, STOP2=1, write 8'h00: parity bit 1, two stop bits, `busy` high 24 clocks.
- DEPTH=4, Prescale=1, six consecutive writes 8'h11..8'h16:
  - `full`=1 after the 5th write and 8'h16 is dropped;
  - five frames 8'h11..8'h15 go out with no gap;
  - `busy` high 50 clocks continuously.
- `RST` pulsed while sending data bit 3 of 8'hFF: `TX_OUT`=1, `busy`=0 and `full`=0 with no clock edge. A later write of 8'h5A produces a correct frame.
- Change PAR_EN, STOP2 and Prescale mid-frame: the current frame is unchanged and the next frame uses the new values.
